rv32_fetch_unit: RTL

- Instruction-fetch front end of the RV32I core.
- Initiator on the instruction-memory read port: drives byte address and enable, and captures the combinational read data in a one-entry output register.
- Owns the PC. Delivers instruction and PC to decode over a valid/ready handshake.
- Handles redirects from execute (branch/jump), backpressure, and address faults.

---
 rtl/rv32_pkg.sv | 12 +
 rtl/rv32_fetch_unit.sv | 107 ++++++++++
 2 files changed

// File: rtl/rv32_pkg.sv
// rv32_pkg: shared constants and types for the rv32 front end
package rv32_pkg;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [1:0] FC_NONE = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_RANGE = 2'b10;
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/rv32_fetch_unit.sv
// rv32_fetch_unit: RV32I instruction fetch, owns the PC and feeds decode over valid/ready
// ports: clk/rst (async high); imem_a/imem_en/imem_rd combinational memory read;
// inst_valid/inst_ready/inst/inst_pc to decode; redirect_valid/redirect_pc from execute;
// fault/fault_cause/fault_pc sticky fault report; fetch_count accepted-instruction counter
module rv32_fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int IMEM_DEPTH = 1024,
  parameter logic [31:0] NOP_INST = rv32_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_a,
  output logic        imem_en,
  input  logic [31:0] imem_rd,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_count
);
  localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);
  fetch_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d, inst_pc_q, inst_pc_d;
  logic [31:0] fault_pc_q, fault_pc_d, fetch_count_q, fetch_count_d;
  logic [1:0] fault_cause_q, fault_cause_d;
  logic inst_valid_q, inst_valid_d, fault_q, fault_d;
  logic run, in_range, room, xfer, fetch_go;
  assign run = state_q == RUN;
  assign in_range = {2'b00, pc_q[31:2]} < DEPTH_W;
  // output register can take a new word this cycle
  assign room = !inst_valid_q || inst_ready;
  assign xfer = inst_valid_q && inst_ready;
  assign fetch_go = run && !redirect_valid && room && in_range;
  assign imem_a = pc_q;
  assign imem_en = fetch_go;
  assign inst_valid = inst_valid_q;
  assign inst = inst_q;
  assign inst_pc = inst_pc_q;
  assign fault = fault_q;
  assign fault_cause = fault_cause_q;
  assign fault_pc = fault_pc_q;
  assign fetch_count = fetch_count_q;
  always_comb begin
    state_d = state_q == BOOT ? RUN : state_q;
    pc_d = pc_q;
    inst_d = xfer ? NOP_INST : inst_q;
    inst_pc_d = inst_pc_q;
    inst_valid_d = xfer ? 1'b0 : inst_valid_q;
    fault_d = fault_q;
    fault_cause_d = fault_cause_q;
    fault_pc_d = fault_pc_q;
    // a handshake in a redirect cycle still counts; the flush below follows it
    fetch_count_d = fetch_count_q + {31'd0, xfer};
    if (run && redirect_valid) begin
      inst_valid_d = 1'b0;
      inst_d = NOP_INST;
      if (redirect_pc[1:0] == 2'b00) begin
        pc_d = redirect_pc;
      end else begin
        state_d = FAULT;
        fault_d = 1'b1;
        fault_cause_d = FC_MISALIGN;
        fault_pc_d = redirect_pc;
      end
    end else if (fetch_go) begin
      inst_d = imem_rd;
      inst_pc_d = pc_q;
      inst_valid_d = 1'b1;
      pc_d = pc_q + 32'd4;
    end else if (run && room && !in_range) begin
      state_d = FAULT;
      fault_d = 1'b1;
      fault_cause_d = FC_RANGE;
      fault_pc_d = pc_q;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q <= RESET_PC;
      inst_q <= NOP_INST;
      inst_pc_q <= '0;
      inst_valid_q <= 1'b0;
      fault_q <= 1'b0;
      fault_cause_q <= FC_NONE;
      fault_pc_q <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      inst_q <= inst_d;
      inst_pc_q <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      fault_q <= fault_d;
      fault_cause_q <= fault_cause_d;
      fault_pc_q <= fault_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end
endmodule
